// File: rtl/wb_bcd_counter_pkg.sv
// Shared definitions for the Wishbone BCD counter: register word offsets,
// CTRL/STATUS bit positions, the BCD digit type and a digit-validity helper.
package wb_bcd_counter_pkg;

  typedef logic [3:0] bcd_t;

  // Word offsets within the 32-byte register window (byte address bits [4:2]).
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_LOAD     = 3'd1,
    REG_COUNT    = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_off_e;

  localparam int unsigned CTRL_RUN        = 0;
  localparam int unsigned CTRL_CLEAR      = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_DOWN       = 3;

  localparam int unsigned STATUS_WRAP     = 0;
  localparam int unsigned STATUS_LOAD_ERR = 1;

  // True when every nibble of a four-digit value is a legal BCD digit.
  function automatic logic is_bcd16(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/wb_bcd_counter_digit.sv
// One decimal digit of the counter. Clear beats load, load beats count.
// Carry/borrow outputs are combinational so a whole chain ripples in one cycle.
module bcd_digit
  import wb_bcd_counter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic inc_i,
  input  logic dec_i,
  output bcd_t digit_o,
  output logic carry_o,
  output logic borrow_o
);

  bcd_t digit_q, digit_d;

  // Next digit value: clear, load, increment with 9->0, decrement with 0->9.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign digit_o  = digit_q;
  assign carry_o  = inc_i & (digit_q == 4'd9);
  assign borrow_o = dec_i & (digit_q == 4'd0);

endmodule

// File: rtl/wb_bcd_counter.sv
// Four-digit BCD counter with a Wishbone classic slave register window,
// programmable prescaler, wrap/load-error status and level interrupt.
// Optional feature: define WB_BCD_COUNTER_DOWN_EN to enable CTRL.DOWN
// (decrement mode, 0000 -> 9999 sets WRAP).
module wb_bcd_counter
  import wb_bcd_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  units,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        irq
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        run_q, run_d;
  logic        irq_en_q, irq_en_d;
  logic        wrap_q, wrap_d;
  logic        lerr_q, lerr_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        down;

`ifdef WB_BCD_COUNTER_DOWN_EN
  logic down_q, down_d;
  assign down = down_q;
`else
  assign down = 1'b0;
`endif

  // Bus decode. A new request is accepted only while no ack is outstanding,
  // so a strobe held through its own ack cycle is not acknowledged twice.
  logic     hit, new_req, wr, rd;
  reg_off_e off;

  assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign new_req = hit & ~ack_q;
  assign wr      = new_req & wbs_we_i;
  assign rd      = new_req & ~wbs_we_i;
  assign off     = reg_off_e'(wbs_adr_i[4:2]);

  logic ctrl_wr, load_wr, status_wr, presc_wr;
  assign ctrl_wr   = wr & (off == REG_CTRL) & wbs_sel_i[0];
  assign load_wr   = wr & (off == REG_LOAD) & (|wbs_sel_i[1:0]);
  assign status_wr = wr & (off == REG_STATUS) & wbs_sel_i[0];
  assign presc_wr  = wr & (off == REG_PRESCALE);

  // Counter datapath.
  bcd_t [3:0]  digit;
  logic [15:0] count;
  logic [15:0] load_val;
  logic [4:0]  cin, bin;
  logic        clear, load_ok, load_go, load_bad, load_en, tick, step, wrap_evt;

  assign count = digit;

  // Unselected LOAD byte lanes keep the digits currently held.
  assign load_val = {wbs_sel_i[1] ? wbs_dat_i[15:8] : count[15:8],
                     wbs_sel_i[0] ? wbs_dat_i[7:0]  : count[7:0]};
  assign load_ok  = is_bcd16(load_val);
  assign load_go  = load_wr & load_ok;
  assign load_bad = load_wr & ~load_ok;
  assign clear    = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
  assign load_en  = load_go & ~clear;

  assign tick     = run_q & (pcnt_q == prescale_q);
  assign step     = tick & ~clear & ~load_go;
  assign cin[0]   = step & ~down;
  assign bin[0]   = step & down;
  assign wrap_evt = step & (down ? bin[4] : cin[4]);

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_rst_ni),
      .clr_i      (clear),
      .load_i     (load_en),
      .load_val_i (load_val[4*g +: 4]),
      .inc_i      (cin[g]),
      .dec_i      (bin[g]),
      .digit_o    (digit[g]),
      .carry_o    (cin[g+1]),
      .borrow_o   (bin[g+1])
    );
  end

  // Read data multiplexer; write-only and unmapped offsets read as zero.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_RUN]    = run_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
        rdata[CTRL_DOWN]   = down;
      end
      REG_COUNT:    rdata[15:0] = count;
      REG_STATUS: begin
        rdata[STATUS_WRAP]     = wrap_q;
        rdata[STATUS_LOAD_ERR] = lerr_q;
      end
      REG_PRESCALE: rdata[15:0] = prescale_q;
      default:      rdata = '0;
    endcase
  end

  // Next-state logic for bus, control, status and prescaler registers.
  always_comb begin
    ack_d      = new_req;
    dat_d      = rd ? rdata : '0;
    run_d      = run_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
`ifdef WB_BCD_COUNTER_DOWN_EN
    down_d     = down_q;
`endif
    if (ctrl_wr) begin
      run_d    = wbs_dat_i[CTRL_RUN];
      irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
`ifdef WB_BCD_COUNTER_DOWN_EN
      down_d   = wbs_dat_i[CTRL_DOWN];
`endif
    end
    if (presc_wr && wbs_sel_i[0]) prescale_d[7:0]  = wbs_dat_i[7:0];
    if (presc_wr && wbs_sel_i[1]) prescale_d[15:8] = wbs_dat_i[15:8];

    // A W1C clear in the same cycle as a new wrap leaves WRAP set.
    wrap_d = (wrap_q & ~(status_wr & wbs_dat_i[STATUS_WRAP])) | wrap_evt;
    lerr_d = (lerr_q & ~(status_wr & wbs_dat_i[STATUS_LOAD_ERR])) | load_bad;

    pcnt_d = pcnt_q;
    if (clear || load_go) pcnt_d = '0;
    else if (run_q)       pcnt_d = tick ? '0 : pcnt_q + 16'd1;
  end

  // Register stage with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      wrap_q     <= 1'b0;
      lerr_q     <= 1'b0;
      prescale_q <= PRESCALE_RST;
      pcnt_q     <= '0;
`ifdef WB_BCD_COUNTER_DOWN_EN
      down_q     <= 1'b0;
`endif
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      run_q      <= run_d;
      irq_en_q   <= irq_en_d;
      wrap_q     <= wrap_d;
      lerr_q     <= lerr_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
`ifdef WB_BCD_COUNTER_DOWN_EN
      down_q     <= down_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign units     = digit[0];
  assign tens      = digit[1];
  assign hundreds  = digit[2];
  assign thousands = digit[3];
  assign irq       = wrap_q & irq_en_q;

  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_bcd_counter.sv
// Self-checking bench for wb_bcd_counter: integer-level reference model,
// expected-response queue, and a negedge monitor comparing every cycle.
module tb_wb_bcd_counter;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [15:0] PRST = 16'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [3:0]  d0, d1, d2, d3;
  logic        irq;

  wb_bcd_counter #(.BASE_ADDR(BASE), .PRESCALE_RST(PRST)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .units(d0), .tens(d1), .hundreds(d2), .thousands(d3), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'(n / 1000);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic int to_int(input logic [15:0] v);
    int s = 0;
    for (int i = 3; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  int          m_count;
  logic [15:0] m_prescale, m_pcnt;
  bit          m_run, m_irq_en, m_down, m_wrap, m_lerr, m_ack;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin : model
    bit          req, nreq, tick, clr, ld, bad, wevt;
    bit [1:0]    w1c;
    logic [2:0]  off;
    logic [15:0] lv;
    int          n_count;
    if (!rst_n) begin
      m_count = 0; m_prescale = PRST; m_pcnt = '0;
      m_run = 0; m_irq_en = 0; m_down = 0; m_wrap = 0; m_lerr = 0; m_ack = 0;
    end else begin
      req  = stb && cyc && (adr[31:5] == BASE[31:5]);
      nreq = req && !m_ack;
      off  = adr[4:2];
      tick = m_run && (m_pcnt == m_prescale);
      clr = 0; ld = 0; bad = 0; w1c = 2'b00; wevt = 0; lv = '0;
      if (nreq && !we) begin
        case (off)
          3'd0:    exp_q.push_back({28'd0, m_down, m_irq_en, 1'b0, m_run});
          3'd2:    exp_q.push_back({16'd0, to_bcd(m_count)});
          3'd3:    exp_q.push_back({30'd0, m_lerr, m_wrap});
          3'd4:    exp_q.push_back({16'd0, m_prescale});
          default: exp_q.push_back(32'd0);
        endcase
      end else if (nreq) begin
        exp_q.push_back(32'd0);
      end
      n_count = m_count;
      if (nreq && we) begin
        case (off)
          3'd0: if (sel[0]) begin
            clr = wdat[1];
          end
          3'd1: if (sel[1:0] != 2'b00) begin
            lv = to_bcd(m_count);
            if (sel[0]) lv[7:0]  = wdat[7:0];
            if (sel[1]) lv[15:8] = wdat[15:8];
            if (bcd_ok(lv)) ld = 1; else bad = 1;
          end
          3'd3: if (sel[0]) w1c = wdat[1:0];
          default: ;
        endcase
      end
      if (clr)      n_count = 0;
      else if (ld)  n_count = to_int(lv);
      else if (tick) begin
        if (m_down) begin wevt = (m_count == 0);    n_count = (m_count + 9999) % 10000; end
        else        begin wevt = (m_count == 9999); n_count = (m_count + 1) % 10000;    end
      end
      if (clr || ld)  m_pcnt = '0;
      else if (m_run) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
      m_wrap  = (m_wrap && !w1c[0]) || wevt;
      m_lerr  = (m_lerr && !w1c[1]) || bad;
      m_count = n_count;
      if (nreq && we && off == 3'd0 && sel[0]) begin
        m_run = wdat[0]; m_irq_en = wdat[2];
`ifdef WB_BCD_COUNTER_DOWN_EN
        m_down = wdat[3];
`endif
      end
      if (nreq && we && off == 3'd4) begin
        if (sel[0]) m_prescale[7:0]  = wdat[7:0];
        if (sel[1]) m_prescale[15:8] = wdat[15:8];
      end
      m_ack = nreq;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    check("count", {16'd0, d3, d2, d1, d0}, {16'd0, to_bcd(m_count)});
    check("irq", {31'd0, irq}, {31'd0, (m_wrap && m_irq_en)});
    check("ack", {31'd0, ack}, {31'd0, m_ack});
    if (m_ack) begin
      e = exp_q.pop_front();
      check("rdata", rdat, e);
    end else begin
      check("idle_dat", rdat, 32'd0);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic xfer(input logic [2:0] off, input bit w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output int lat);
    bit got = 0;
    @(negedge clk);
    stb = 1; cyc = 1; we = w; sel = s; wdat = d; adr = BASE | {27'd0, off, 2'b00};
    r = '0; lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; r = rdat; lat = i; break; end
    end
    stb = 0; cyc = 0; we = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout off=%0d got=none exp=ack", off);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] r; int l;
    xfer(off, 1'b1, d, 4'hF, r, l);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] r);
    int l;
    xfer(off, 1'b0, 32'd0, 4'hF, r, l);
  endtask

  task automatic miss();
    @(negedge clk);
    stb = 1; cyc = 1; we = $urandom_range(0, 1); sel = 4'hF;
    adr = BASE + 32'h0000_0100; wdat = $urandom;
    repeat (3) @(negedge clk);
    stb = 0; cyc = 0; we = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] r;
    int          lat;
    rst_n = 0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Reset state and single-cycle ack latency.
    xfer(3'd2, 1'b0, 32'd0, 4'hF, r, lat);
    check("reset_count", r, 32'h0000_0000);
    check("ack_latency", lat, 1);
    rd(3'd4, r); check("reset_prescale", r, {16'd0, PRST});

    // Prescale 3: a tick every 4 cycles.
    wr(3'd4, 32'd3);
    wr(3'd0, 32'h3);
    repeat (39) @(negedge clk);
    check("presc_39cyc", {16'd0, d3, d2, d1, d0}, 32'h0009);
    @(negedge clk);
    check("presc_40cyc", {16'd0, d3, d2, d1, d0}, 32'h0010);
    wr(3'd0, 32'h0);

    // Wrap 9999 -> 0000, interrupt, W1C.
    wr(3'd4, 32'd0);
    wr(3'd1, 32'h9998);
    wr(3'd0, 32'h5);
    @(negedge clk); check("to_9999", {16'd0, d3, d2, d1, d0}, 32'h9999);
    @(negedge clk); check("to_0000", {16'd0, d3, d2, d1, d0}, 32'h0000);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'h4);
    rd(3'd3, r); check("status_wrap", r, 32'h1);
    wr(3'd3, 32'h1);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd(3'd3, r); check("status_clr", r, 32'h0);

    // Invalid load rejected; clear after load.
    wr(3'd1, 32'h0042);
    wr(3'd1, 32'h12A4);
    rd(3'd2, r); check("bad_load_count", r, 32'h0042);
    rd(3'd3, r); check("load_err", r, 32'h2);
    wr(3'd3, 32'h2);
    wr(3'd1, 32'h1234);
    wr(3'd0, 32'h2);
    rd(3'd2, r); check("clear_count", r, 32'h0000);
    rd(3'd0, r); check("clear_reads0", r, 32'h0);

    // Reset in the middle of a transaction.
    wr(3'd1, 32'h9999);
    wr(3'd0, 32'h5);
    repeat (2) @(negedge clk);
    wr(3'd0, 32'h4);
    wr(3'd1, 32'h0537);
    check("pre_rst_count", {16'd0, d3, d2, d1, d0}, 32'h0537);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; sel = 4'hF; adr = BASE | 32'h8; rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", {31'd0, ack}, 32'd0);
      check("rst_outs", {11'd0, irq, rdat[15:0], d3, d2, d1, d0}, 32'd0);
    end
    stb = 0; cyc = 0; rst_n = 1;
    rd(3'd4, r); check("rst_prescale", r, {16'd0, PRST});
    rd(3'd0, r); check("rst_ctrl", r, 32'h0);

`ifdef WB_BCD_COUNTER_DOWN_EN
    wr(3'd4, 32'd0);
    wr(3'd1, 32'h0001);
    wr(3'd0, 32'h9);
    @(negedge clk); check("down_0000", {16'd0, d3, d2, d1, d0}, 32'h0000);
    @(negedge clk); check("down_9999", {16'd0, d3, d2, d1, d0}, 32'h9999);
    wr(3'd0, 32'h0);
    rd(3'd3, r); check("down_wrap", r, 32'h1);
`else
    wr(3'd0, 32'h8);
    rd(3'd0, r); check("no_down_bit", r, 32'h0);
`endif

    // Randomized traffic against the model.
    wr(3'd4, 32'd1);
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  o;
      logic [31:0] d;
      logic [3:0]  s;
      int          l;
      if ($urandom_range(0, 9) == 0) begin
        miss();
      end else begin
        o = 3'($urandom_range(0, 7));
        case (o)
          3'd1:    d = ($urandom_range(0, 4) == 0) ? $urandom
                       : {16'd0, to_bcd(($urandom_range(0, 1) == 1) ? $urandom_range(9990, 9999)
                                                                      : $urandom_range(0, 9999))};
          3'd4:    d = $urandom_range(0, 3);
          3'd0:    d = $urandom_range(0, 15);
          default: d = $urandom;
        endcase
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        xfer(o, 1'($urandom_range(0, 1)), d, s, r, l);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
